// File: rtl/sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the task scheduler back end.
//   - State encodings of the dispatcher FSM, kept as plain localparam
//     constants so older tools and netlists see stable encodings.
//   - schedClog2: ceiling log2 used to size task and core index fields.
//     It never returns less than 1, so a one-entry field still has a bit.
// -----------------------------------------------------------------------------
package sched_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Smallest width w (at least 1) such that 2**w >= value.
    function automatic int schedClog2(input int value);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= value) begin
                return w;
            end
        end
        return 31;
    endfunction

endpackage

// File: rtl/core_onehot_decode.sv
// -----------------------------------------------------------------------------
// core_onehot_decode
// Purely combinational decode of one task's column of the processor
// assignment map. A healthy column has exactly one bit set; its position is
// the core the task must run on.
// Ports:
//   i_column   in   NUM_PROCESSORS  bit p set => task belongs to core p
//   o_coreIdx  out  CORE_W          index of the set bit (highest if several)
//   o_none     out  1               no bit set in the column
//   o_multi    out  1               more than one bit set in the column
// -----------------------------------------------------------------------------
module core_onehot_decode
    import sched_pkg::*;
#(
    parameter int NUM_PROCESSORS = 3,
    parameter int CORE_W         = schedClog2(NUM_PROCESSORS)
) (
    input  logic [NUM_PROCESSORS-1:0] i_column,
    output logic [CORE_W-1:0]         o_coreIdx,
    output logic                      o_none,
    output logic                      o_multi
);

    // Count the set bits while remembering the last one seen. The index is
    // only meaningful when neither flag is raised, so picking the highest
    // bit on a malformed column is harmless.
    always_comb begin
        int bitCount;
        bitCount  = 0;
        o_coreIdx = '0;
        for (int p = 0; p < NUM_PROCESSORS; p++) begin
            if (i_column[p]) begin
                bitCount  = bitCount + 1;
                o_coreIdx = CORE_W'(p);
            end
        end
        o_none  = (bitCount == 0);
        o_multi = (bitCount > 1);
    end

endmodule

// File: rtl/task_dispatcher.sv
// -----------------------------------------------------------------------------
// task_dispatcher
// Downstream stage of the task scheduler. When the scheduler finishes it
// pulses start; this block latches the processor assignment map and the
// per-task frequencies, then hands tasks to their cores one at a time in
// ascending task order, waiting whenever the target core is still busy.
// Completion pulses from the cores free them again. The run ends with a
// one-cycle all_done pulse and a cycle-accurate makespan.
// Ports:
//   clk                   in   rising-edge clock
//   reset                 in   synchronous, active-low reset
//   start                 in   run request, honoured only when idle
//   processor_assignment  in   bit p*NUM_TASKS+t set => task t on core p
//   freq_in               in   task t frequency at [t*DATA_WIDTH +: DATA_WIDTH]
//   core_done             in   bit p pulses when core p finishes its task
//   disp_valid            out  one-hot pulse handing a task to a core
//   disp_task_id          out  task index, zero when nothing is dispatched
//   disp_freq             out  task frequency, zero when nothing is dispatched
//   busy                  out  high from LATCH through DONE
//   all_done              out  one-cycle pulse at the end of a run
//   makespan              out  cycles spent LATCH..DONE, held until next start
//   assign_err            out  sticky per run, a column was empty or multi-hot
// -----------------------------------------------------------------------------
module task_dispatcher
    import sched_pkg::*;
#(
    parameter int NUM_TASKS      = 10,
    parameter int NUM_PROCESSORS = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TASK_ID_W      = schedClog2(NUM_TASKS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [0:NUM_PROCESSORS*NUM_TASKS-1]   processor_assignment,
    input  logic [0:DATA_WIDTH*NUM_TASKS-1]       freq_in,
    input  logic [NUM_PROCESSORS-1:0]             core_done,
    output logic [NUM_PROCESSORS-1:0]             disp_valid,
    output logic [TASK_ID_W-1:0]                  disp_task_id,
    output logic [DATA_WIDTH-1:0]                 disp_freq,
    output logic                                  busy,
    output logic                                  all_done,
    output logic [DATA_WIDTH-1:0]                 makespan,
    output logic                                  assign_err
);

    localparam int CORE_W = schedClog2(NUM_PROCESSORS);

    logic [2:0]                                r_state;
    logic [0:NUM_PROCESSORS*NUM_TASKS-1]       r_assign;
    logic [0:DATA_WIDTH*NUM_TASKS-1]           r_freq;
    logic [TASK_ID_W-1:0]                      r_ptr;
    logic [NUM_PROCESSORS-1:0]                 r_busyCore;
    logic [DATA_WIDTH-1:0]                     r_makespan;
    logic                                      r_assignErr;
    logic [NUM_PROCESSORS-1:0]                 r_dispValid;
    logic [TASK_ID_W-1:0]                      r_dispTaskId;
    logic [DATA_WIDTH-1:0]                     r_dispFreq;

    logic [NUM_PROCESSORS-1:0]                 w_column;
    logic [DATA_WIDTH-1:0]                     w_taskFreq;
    logic [CORE_W-1:0]                         w_coreIdx;
    logic                                      w_none;
    logic                                      w_multi;
    logic [NUM_PROCESSORS-1:0]                 w_coreMask;
    logic                                      w_coreFree;
    logic                                      w_lastTask;
    logic                                      w_badColumn;
    logic                                      w_dispatch;
    logic [NUM_PROCESSORS-1:0]                 w_setMask;

    // Select the current task's column and frequency with a compare-based
    // mux over all task slots, so only constant bit positions are indexed.
    always_comb begin
        w_column   = '0;
        w_taskFreq = '0;
        for (int t = 0; t < NUM_TASKS; t++) begin
            if (r_ptr == TASK_ID_W'(t)) begin
                w_taskFreq = r_freq[t*DATA_WIDTH +: DATA_WIDTH];
                for (int p = 0; p < NUM_PROCESSORS; p++) begin
                    w_column[p] = r_assign[p*NUM_TASKS + t];
                end
            end
        end
    end

    core_onehot_decode #(
        .NUM_PROCESSORS (NUM_PROCESSORS),
        .CORE_W         (CORE_W)
    ) u_decode (
        .i_column  (w_column),
        .o_coreIdx (w_coreIdx),
        .o_none    (w_none),
        .o_multi   (w_multi)
    );

    // Issue decision for the current pointer. The registered busy vector is
    // used on purpose: a completion pulse only frees its core at the next
    // edge, so a stalled task leaves two edges after the ack, never sooner.
    always_comb begin
        w_coreMask  = NUM_PROCESSORS'(1) << w_coreIdx;
        w_coreFree  = ((r_busyCore & w_coreMask) == '0);
        w_lastTask  = (r_ptr == TASK_ID_W'(NUM_TASKS - 1));
        w_badColumn = w_none | w_multi;
        w_dispatch  = (r_state == S_ISSUE) && !w_badColumn && w_coreFree;
        w_setMask   = w_dispatch ? w_coreMask : '0;
    end

    // Main sequential block: FSM, latched maps, task pointer, per-core busy
    // bits, makespan counter and the registered dispatch port. The dispatch
    // port defaults to zero every cycle so it only ever pulses. A core is only
    // marked busy when it was free, so a completion pulse on that same core in
    // that same cycle belongs to an idle core and is rightly ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_assign     <= '0;
            r_freq       <= '0;
            r_ptr        <= '0;
            r_busyCore   <= '0;
            r_makespan   <= '0;
            r_assignErr  <= 1'b0;
            r_dispValid  <= '0;
            r_dispTaskId <= '0;
            r_dispFreq   <= '0;
        end else begin
            r_dispValid  <= '0;
            r_dispTaskId <= '0;
            r_dispFreq   <= '0;
            r_busyCore   <= (r_busyCore & ~core_done) | w_setMask;

            if ((r_state != S_IDLE) && (r_makespan != '1)) begin
                r_makespan <= r_makespan + DATA_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_assign    <= processor_assignment;
                        r_freq      <= freq_in;
                        r_makespan  <= '0;
                        r_assignErr <= 1'b0;
                        r_ptr       <= '0;
                        r_state     <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    r_ptr   <= '0;
                    r_state <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (w_badColumn || w_coreFree) begin
                        if (w_badColumn) begin
                            r_assignErr <= 1'b1;
                        end else begin
                            r_dispValid  <= w_coreMask;
                            r_dispTaskId <= r_ptr;
                            r_dispFreq   <= w_taskFreq;
                        end
                        if (w_lastTask) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_ptr <= r_ptr + TASK_ID_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (r_busyCore == '0) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs follow directly from the state so a reset clears them
    // on the same edge as the FSM.
    assign busy         = (r_state != S_IDLE);
    assign all_done     = (r_state == S_DONE);
    assign makespan     = r_makespan;
    assign assign_err   = r_assignErr;
    assign disp_valid   = r_dispValid;
    assign disp_task_id = r_dispTaskId;
    assign disp_freq    = r_dispFreq;

endmodule
